stop_watch_lap_ctrl: RTL and testbench
======================================

Name: stop_watch_lap_ctrl

Overview:
Parametrised stopwatch controller with its own time base. It adds lap capture into a LAP_DEPTH-entry buffer, lap recall browsing, and rollover signalling. It sits between the debounced button pulses / FSM_Top mode select and the FND display mux. It replaces the bare run/clear controller plus external counter.

Parameters:
TICK_DIV, 1_000_000, iClk cycles per 1/100 s tick (sim uses 4); legal range >= 2
LAP_DEPTH, 4, number of lap registers; legal range 1..15
LAP_IDX_W, 4, width of lap index/count outputs; must hold LAP_DEPTH

Ports:
iClk  in  1  system clock
iRst  in  1  reset; one clock, synchronous, active-high
iStop_Watch  in  1  stopwatch mode selected; all buttons ignored when low
iBtn_L  in  1  1-cycle pulse; clear (STOP) / lap (RUN) / exit (VIEW)
iBtn_R  in  1  1-cycle pulse; run/stop toggle; exit in VIEW
iBtn_U  in  1  1-cycle pulse; enter VIEW / next lap
oRun_Stop  out  1  high in RUN
oClear  out  1  high exactly while state == CLEAR
oLap_View  out  1  high in VIEW
oCsec  out  7  displayed centiseconds 0..99
oSec  out  6  displayed seconds 0..59
oMin  out  6  displayed minutes 0..59
oLap_Idx  out  LAP_IDX_W  lap being shown in VIEW, else 0
oLap_Cnt  out  LAP_IDX_W  laps stored, 0..LAP_DEPTH
oLap_Full  out  1  high when oLap_Cnt == LAP_DEPTH
oWrap  out  1  1-cycle pulse on 59:59.99 -> 00:00.00

Behaviour:
- Reset (sync, iRst high at posedge):
  - state = STOP; time, prescaler, lap count, view index = 0.
  - All outputs 0. Lap register contents are don't-care.
- btn_x = iBtn_x & iStop_Watch. Running/counting is NOT gated by iStop_Watch.
- States: STOP, RUN, CLEAR, VIEW (2-bit encoding).
- STOP:
  - btn_L -> CLEAR (priority over R, U).
  - else btn_R -> RUN.
  - else btn_U with oLap_Cnt > 0 -> VIEW with oLap_Idx = 0.
  - btn_U with oLap_Cnt == 0 is ignored.
- RUN:
  - btn_R -> STOP. L on the same cycle is ignored.
  - else btn_L -> lap capture; state stays RUN. btn_U is ignored.
- CLEAR:
  - Unconditional -> STOP after 1 cycle.
  - At that edge, time, prescaler, lap count and index become 0.
  - Zero time is visible on the first STOP cycle.
- VIEW:
  - btn_U: oLap_Idx += 1, wrapping to 0 after oLap_Cnt-1.
  - btn_L or btn_R -> STOP. Time is unchanged and RUN is not entered.
- Time base:
  - Prescaler counts 0..TICK_DIV-1 only in RUN; it holds its value in STOP and VIEW.
  - tick = RUN & prescaler == TICK_DIV-1.
  - Tick increments Csec. 99 wraps to 0 and carries into Sec; 59 wraps to 0 and carries into Min.
  - Min 59 wraps to 0 and asserts oWrap for that one cycle.
- Lap capture:
  - If oLap_Cnt < LAP_DEPTH: store {Min, Sec, Csec} as registered in the capture cycle (the pre-tick value if a tick coincides) into entry oLap_Cnt, then oLap_Cnt += 1 next cycle.
  - If full: capture dropped, no overwrite, count unchanged, oLap_Full stays 1.
- Display mux:
  - VIEW: oCsec/oSec/oMin = lap[oLap_Idx].
  - Otherwise: live time.
  - Registered, with the same update edge as the state.
- oRun_Stop, oLap_View and oClear are decoded directly from the current state register.
- oLap_Full is combinational from the count.
- iStop_Watch falling in RUN: counting continues.
- iStop_Watch low in VIEW: state is held.
- Reset mid-RUN aborts immediately; no clear pulse is generated.

Test Plan:
- TICK_DIV=4; reset, R pulse, wait 400 cycles -> oRun_Stop=1, oCsec=0 oSec=1 oMin=0; R -> holds 00:01.00 for 100 cycles.
- In RUN, L at 00:00.05, 00:00.09, 00:00.20, 00:00.31, 00:00.40 (LAP_DEPTH=4) -> oLap_Cnt=4, oLap_Full=1, fifth capture dropped.
- Stop, U,U,U,U,U -> oLap_View=1, oLap_Idx 0,1,2,3,0; display shows 05,09,20,31,05 cs; R -> STOP, live time shown, oRun_Stop=0.
- From STOP, L -> oClear high exactly 1 cycle, next cycle time=00:00.00, oLap_Cnt=0, oLap_Full=0; U then ignored (stays STOP).
- Preload to 59:59.99 via running, one more tick -> 00:00.00, oWrap 1 cycle; L coinciding with a tick stores pre-tick value.
- iStop_Watch=0 with R/L/U pulses in STOP and RUN -> no state change; counting in RUN continues; iRst mid-RUN -> all outputs 0 next cycle, oClear stays 0.

Source files
------------

// File: rtl/stop_watch_lap_ctrl_if.sv
// Button/mode inputs and display/status outputs of the stopwatch lap controller.
// The controller side uses the slave modport; the driver of the buttons uses master.
interface stop_watch_lap_ctrl_if #(
  parameter int LAP_IDX_W = 4
);
  logic                 iStop_Watch;
  logic                 iBtn_L;
  logic                 iBtn_R;
  logic                 iBtn_U;
  logic                 oRun_Stop;
  logic                 oClear;
  logic                 oLap_View;
  logic [6:0]           oCsec;
  logic [5:0]           oSec;
  logic [5:0]           oMin;
  logic [LAP_IDX_W-1:0] oLap_Idx;
  logic [LAP_IDX_W-1:0] oLap_Cnt;
  logic                 oLap_Full;
  logic                 oWrap;

  modport slave (
    input  iStop_Watch, iBtn_L, iBtn_R, iBtn_U,
    output oRun_Stop, oClear, oLap_View, oCsec, oSec, oMin,
    output oLap_Idx, oLap_Cnt, oLap_Full, oWrap
  );

  modport master (
    output iStop_Watch, iBtn_L, iBtn_R, iBtn_U,
    input  oRun_Stop, oClear, oLap_View, oCsec, oSec, oMin,
    input  oLap_Idx, oLap_Cnt, oLap_Full, oWrap
  );
endinterface

// File: rtl/stop_watch_lap_ctrl.sv
// Stopwatch controller: own 1/100 s time base, lap capture buffer, lap recall
// browsing and rollover pulse, with a registered display mux.
module stop_watch_lap_ctrl #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int LAP_DEPTH = 4,
  parameter int LAP_IDX_W = 4
) (
  input  logic                        iClk,
  input  logic                        iRst,
  stop_watch_lap_ctrl_if.slave        bus
);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_VIEW  = 2'd3;

  localparam int                   PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]        PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [LAP_IDX_W-1:0] DEPTH_C   = LAP_IDX_W'(LAP_DEPTH);
  localparam logic [LAP_IDX_W-1:0] IDX_ONE   = LAP_IDX_W'(1);

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] csec;
  } stamp_t;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  stamp_t               live_q, live_d;
  stamp_t               disp_q, disp_d;
  logic [LAP_IDX_W-1:0] lap_cnt_q, lap_cnt_d;
  logic [LAP_IDX_W-1:0] lap_idx_q, lap_idx_d;
  logic                 wrap_q, wrap_d;
  logic                 lap_wr;
  logic                 lap_full;
  logic                 tick;
  logic                 btn_l, btn_r, btn_u;
  stamp_t               rd_lap;
  stamp_t               lap_mem [LAP_DEPTH];

  assign btn_l    = bus.iBtn_L & bus.iStop_Watch;
  assign btn_r    = bus.iBtn_R & bus.iStop_Watch;
  assign btn_u    = bus.iBtn_U & bus.iStop_Watch;
  assign lap_full = (lap_cnt_q == DEPTH_C);
  assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    lap_cnt_d = lap_cnt_q;
    lap_idx_d = lap_idx_q;
    lap_wr    = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (btn_l)                              state_d = ST_CLEAR;
        else if (btn_r)                         state_d = ST_RUN;
        else if (btn_u && lap_cnt_q != '0) begin
          state_d   = ST_VIEW;
          lap_idx_d = '0;
        end
      end
      ST_RUN: begin
        if (btn_r)                       state_d = ST_STOP;
        else if (btn_l && !lap_full) begin
          lap_wr    = 1'b1;
          lap_cnt_d = lap_cnt_q + IDX_ONE;
        end
      end
      ST_CLEAR: begin
        state_d   = ST_STOP;
        lap_cnt_d = '0;
        lap_idx_d = '0;
      end
      default: begin
        if (btn_l || btn_r) begin
          state_d   = ST_STOP;
          lap_idx_d = '0;
        end else if (btn_u) begin
          lap_idx_d = (lap_idx_q == lap_cnt_q - IDX_ONE) ? '0 : lap_idx_q + IDX_ONE;
        end
      end
    endcase
  end

  // Time base: prescaler advances only in RUN; a tick ripples csec -> sec -> min.
  always_comb begin
    live_d  = live_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (state_q == ST_CLEAR) begin
      live_d  = '0;
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (live_q.csec != 7'd99) begin
          live_d.csec = live_q.csec + 7'd1;
        end else begin
          live_d.csec = '0;
          if (live_q.sec != 6'd59) begin
            live_d.sec = live_q.sec + 6'd1;
          end else begin
            live_d.sec = '0;
            if (live_q.min != 6'd59) begin
              live_d.min = live_q.min + 6'd1;
            end else begin
              live_d.min = '0;
              wrap_d     = 1'b1;
            end
          end
        end
      end
    end
  end

  // Display is chosen from next-state values so it changes on the same edge as the state.
  always_comb begin
    rd_lap = '0;
    for (int i = 0; i < LAP_DEPTH; i++) begin
      if (lap_idx_d == LAP_IDX_W'(i)) rd_lap = lap_mem[i];
    end
    disp_d = (state_d == ST_VIEW) ? rd_lap : live_d;
  end

  // NOTE: lap registers have no reset; entries at or beyond the lap count are never shown.
  always_ff @(posedge iClk) begin
    for (int i = 0; i < LAP_DEPTH; i++) begin
      if (lap_wr && lap_cnt_q == LAP_IDX_W'(i)) lap_mem[i] <= live_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= ST_STOP;
      presc_q   <= '0;
      live_q    <= '0;
      disp_q    <= '0;
      lap_cnt_q <= '0;
      lap_idx_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      live_q    <= live_d;
      disp_q    <= disp_d;
      lap_cnt_q <= lap_cnt_d;
      lap_idx_q <= lap_idx_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.oRun_Stop = (state_q == ST_RUN);
  assign bus.oClear    = (state_q == ST_CLEAR);
  assign bus.oLap_View = (state_q == ST_VIEW);
  assign bus.oCsec     = disp_q.csec;
  assign bus.oSec      = disp_q.sec;
  assign bus.oMin      = disp_q.min;
  assign bus.oLap_Idx  = lap_idx_q;
  assign bus.oLap_Cnt  = lap_cnt_q;
  assign bus.oLap_Full = lap_full;
  assign bus.oWrap     = wrap_q;

endmodule

// File: tb/tb_stop_watch_lap_ctrl.sv
// Self-checking bench for stop_watch_lap_ctrl (TICK_DIV=4, LAP_DEPTH=4): the driver
// applies stimulus and compares hand-computed expectations at each falling edge.
module tb_stop_watch_lap_ctrl;

  typedef struct packed {
    logic       run;
    logic       clr;
    logic       view;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] csec;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic       full;
    logic       wrap;
  } out_t;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;

  logic  clk;
  logic  rst;
  int    checks;
  int    errors;

  stop_watch_lap_ctrl_if #(.LAP_IDX_W(4)) bus ();

  stop_watch_lap_ctrl #(
    .TICK_DIV (4),
    .LAP_DEPTH(4),
    .LAP_IDX_W(4)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string fmt(input out_t v);
    return $sformatf("run=%0b clr=%0b view=%0b %0d:%0d.%0d idx=%0d cnt=%0d full=%0b wrap=%0b",
                     v.run, v.clr, v.view, v.min, v.sec, v.csec, v.idx, v.cnt, v.full, v.wrap);
  endfunction

  task automatic check(input string name, input logic ok, input string detail);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      BTN_L:   bus.iBtn_L = 1'b1;
      BTN_R:   bus.iBtn_R = 1'b1;
      default: bus.iBtn_U = 1'b1;
    endcase
    @(posedge clk);
    #1;
    bus.iBtn_L = 1'b0;
    bus.iBtn_R = 1'b0;
    bus.iBtn_U = 1'b0;
  endtask

  task automatic expect_o(input string name, input logic run, input logic clr, input logic view,
                          input int mn, input int sc, input int cs, input int idx, input int cnt,
                          input logic full, input logic wrap);
    out_t e;
    out_t g;
    e.run  = run;
    e.clr  = clr;
    e.view = view;
    e.min  = 6'(mn);
    e.sec  = 6'(sc);
    e.csec = 7'(cs);
    e.idx  = 4'(idx);
    e.cnt  = 4'(cnt);
    e.full = full;
    e.wrap = wrap;
    @(negedge clk);
    g = {bus.oRun_Stop, bus.oClear, bus.oLap_View, bus.oMin, bus.oSec, bus.oCsec,
         bus.oLap_Idx, bus.oLap_Cnt, bus.oLap_Full, bus.oWrap};
    check(name, g === e, $sformatf("got %s expected %s", fmt(g), fmt(e)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.iStop_Watch = 1'b1;
    bus.iBtn_L      = 1'b0;
    bus.iBtn_R      = 1'b0;
    bus.iBtn_U      = 1'b0;
    cycles(2);
    rst = 1'b0;
    expect_o("reset", 0,0,0, 0,0,0, 0,0, 0,0);

    // Run one second, stop and hold
    pulse(BTN_R);
    cycles(400);
    expect_o("run_1s", 1,0,0, 0,1,0, 0,0, 0,0);
    pulse(BTN_R);
    cycles(100);
    expect_o("stop_hold", 0,0,0, 0,1,0, 0,0, 0,0);
    pulse(BTN_L);
    expect_o("clear_pulse", 0,1,0, 0,1,0, 0,0, 0,0);
    cycles(1);
    expect_o("clear_zero", 0,0,0, 0,0,0, 0,0, 0,0);
    check("clear_full_low", bus.oLap_Full === 1'b0,
          $sformatf("oLap_Full=%0b expected 0", bus.oLap_Full));

    // Lap captures at 05, 09, 20, 31 cs; fifth at 40 cs dropped
    pulse(BTN_R);
    cycles(21);
    pulse(BTN_L);
    expect_o("lap1", 1,0,0, 0,0,5, 0,1, 0,0);
    cycles(15);
    pulse(BTN_L);
    cycles(43);
    pulse(BTN_L);
    cycles(43);
    pulse(BTN_L);
    expect_o("lap4_full", 1,0,0, 0,0,31, 0,4, 1,0);
    check("full_flag_high", bus.oLap_Full === 1'b1,
          $sformatf("oLap_Full=%0b expected 1", bus.oLap_Full));
    cycles(35);
    pulse(BTN_L);
    expect_o("lap5_drop", 1,0,0, 0,0,40, 0,4, 1,0);
    cycles(37);
    pulse(BTN_R);
    expect_o("stop_50", 0,0,0, 0,0,50, 0,4, 1,0);

    // Lap recall browsing
    pulse(BTN_U);
    expect_o("view0", 0,0,1, 0,0,5, 0,4, 1,0);
    pulse(BTN_U);
    expect_o("view1", 0,0,1, 0,0,9, 1,4, 1,0);
    pulse(BTN_U);
    expect_o("view2", 0,0,1, 0,0,20, 2,4, 1,0);
    pulse(BTN_U);
    expect_o("view3", 0,0,1, 0,0,31, 3,4, 1,0);
    pulse(BTN_U);
    expect_o("view_wrap", 0,0,1, 0,0,5, 0,4, 1,0);
    bus.iStop_Watch = 1'b0;
    pulse(BTN_R);
    expect_o("view_hold_sw", 0,0,1, 0,0,5, 0,4, 1,0);
    bus.iStop_Watch = 1'b1;
    pulse(BTN_R);
    expect_o("view_exit_r", 0,0,0, 0,0,50, 0,4, 1,0);

    // Clear drops laps; U with no laps ignored
    pulse(BTN_L);
    expect_o("clear2", 0,1,0, 0,0,50, 0,4, 1,0);
    cycles(1);
    expect_o("clear2_zero", 0,0,0, 0,0,0, 0,0, 0,0);
    pulse(BTN_U);
    expect_o("u_ignored", 0,0,0, 0,0,0, 0,0, 0,0);

    // Rollover: preload 59:59.99 while stopped, then one tick
    force dut.live_q = {6'd59, 6'd59, 7'd99};
    cycles(1);
    release dut.live_q;
    expect_o("preload", 0,0,0, 59,59,99, 0,0, 0,0);
    pulse(BTN_R);
    cycles(3);
    expect_o("pre_wrap", 1,0,0, 59,59,99, 0,0, 0,0);
    cycles(1);
    expect_o("wrap", 1,0,0, 0,0,0, 0,0, 0,1);
    check("wrap_pulse_high", bus.oWrap === 1'b1,
          $sformatf("oWrap=%0b expected 1", bus.oWrap));
    cycles(1);
    expect_o("wrap_done", 1,0,0, 0,0,0, 0,0, 0,0);
    check("wrap_one_cycle", bus.oWrap === 1'b0,
          $sformatf("oWrap=%0b expected 0", bus.oWrap));

    // Capture on a tick edge stores the pre-tick value (00:00.01)
    cycles(6);
    pulse(BTN_L);
    expect_o("lap_on_tick", 1,0,0, 0,0,2, 0,1, 0,0);
    pulse(BTN_R);
    expect_o("stop_02", 0,0,0, 0,0,2, 0,1, 0,0);
    pulse(BTN_U);
    expect_o("view_tick_lap", 0,0,1, 0,0,1, 0,1, 0,0);
    pulse(BTN_U);
    expect_o("view_wrap_one", 0,0,1, 0,0,1, 0,1, 0,0);
    pulse(BTN_L);
    expect_o("view_exit_l", 0,0,0, 0,0,2, 0,1, 0,0);

    // Mode deselected: buttons ignored, counting continues
    bus.iStop_Watch = 1'b0;
    pulse(BTN_R);
    pulse(BTN_L);
    pulse(BTN_U);
    expect_o("sw_low_stop", 0,0,0, 0,0,2, 0,1, 0,0);
    bus.iStop_Watch = 1'b1;
    pulse(BTN_R);
    bus.iStop_Watch = 1'b0;
    pulse(BTN_R);
    pulse(BTN_L);
    pulse(BTN_U);
    expect_o("sw_low_run", 1,0,0, 0,0,3, 0,1, 0,0);
    check("sw_low_still_run", bus.oRun_Stop === 1'b1,
          $sformatf("oRun_Stop=%0b expected 1", bus.oRun_Stop));
    cycles(8);
    expect_o("run_continues", 1,0,0, 0,0,5, 0,1, 0,0);

    // Reset mid-run
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    expect_o("rst_mid_run", 0,0,0, 0,0,0, 0,0, 0,0);
    cycles(2);
    expect_o("rst_no_clear", 0,0,0, 0,0,0, 0,0, 0,0);
    check("rst_clear_low", bus.oClear === 1'b0,
          $sformatf("oClear=%0b expected 0", bus.oClear));

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
